// File: rtl/rf_sched_pkg.sv
// rtl/rf_sched_pkg.sv - shared types and constants for the register-file write scheduler
//  Starvation FSM state encoding, zero-register constant and register-file geometry.
package rf_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } sched_state_t;

    localparam int         NUM_REGS = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy vector, pending counter and issue hazard check
//  clk, rst_n          clock, asynchronous active-low reset
//  iss_valid/iss_long  issue stage holds an instruction / it completes via source B
//  iss_rs/rt/rd        operand and destination registers of the issuing instruction
//  force_stall         starvation FSM demands the issue stage hold
//  clr_en/clr_rw       source B write accepted this cycle and its destination
//  iss_stall           hold issue stage
//  busy                registers with an outstanding long-latency write (bit0 always 0)
//  pending_cnt         number of outstanding long-latency writes
module rf_scoreboard
    import rf_sched_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid,
    input  logic                iss_long,
    input  logic [REG_AW-1:0]   iss_rs,
    input  logic [REG_AW-1:0]   iss_rt,
    input  logic [REG_AW-1:0]   iss_rd,
    input  logic                force_stall,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_rw,
    output logic                iss_stall,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    pending_cnt
);

    logic                pend_full;
    logic                set_en;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    assign pend_full = (pending_cnt == CNT_W'(MAX_PENDING));

    // Hazards are checked against the registered busy vector, so a register
    // released by source B this cycle still holds issue for one more cycle.
    assign iss_stall = rst_n & iss_valid
                     & (busy[iss_rs] | busy[iss_rt] | busy[iss_rd]
                        | (iss_long & pend_full) | force_stall);

    // A long op to r0 still occupies a pending slot; it only skips the busy bit.
    assign set_en = iss_valid & ~iss_stall & iss_long;

    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_rw] = 1'b0;
        end
        if (set_en && (iss_rd != REG_AW'(REG_ZERO))) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = pending_cnt;
        case ({set_en, clr_en})
            2'b10:   cnt_nxt = pending_cnt + CNT_W'(1);
            2'b01:   cnt_nxt = pending_cnt - CNT_W'(1);
            default: cnt_nxt = pending_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(clr_en && !set_en && (pending_cnt == '0)));

endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - shares the register-file write port between WB and a long-latency unit
//  clk, rst_n              clock, asynchronous active-low reset
//  wb_le/wb_rw/wb_pw       source A: in-order pipeline writeback
//  lu_valid/lu_rw/lu_pw    source B request, held until lu_ready
//  lu_ready                source B granted this cycle
//  iss_valid/iss_long      issue stage instruction present / completes via source B
//  iss_rs/iss_rt/iss_rd    issuing instruction registers
//  iss_stall               hold issue stage
//  pipe_stall              freeze pipeline so source B can drain
//  rf_le/rf_rw/rf_pw       register-file write port
//  sb_busy, pending_cnt    scoreboard state
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_le,
    input  logic [REG_AW-1:0]   wb_rw,
    input  logic [DATA_W-1:0]   wb_pw,
    input  logic                lu_valid,
    input  logic [REG_AW-1:0]   lu_rw,
    input  logic [DATA_W-1:0]   lu_pw,
    output logic                lu_ready,
    input  logic                iss_valid,
    input  logic                iss_long,
    input  logic [REG_AW-1:0]   iss_rs,
    input  logic [REG_AW-1:0]   iss_rt,
    input  logic [REG_AW-1:0]   iss_rd,
    output logic                iss_stall,
    output logic                pipe_stall,
    output logic                rf_le,
    output logic [REG_AW-1:0]   rf_rw,
    output logic [DATA_W-1:0]   rf_pw,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic [CNT_W-1:0]    pending_cnt
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic              a_act;
    sched_state_t      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force_q;

    // A write to r0 from the pipeline is not a write and does not claim the port.
    assign a_act = wb_le & (wb_rw != REG_AW'(REG_ZERO));

    assign lu_ready = rst_n & lu_valid & ~a_act;

    always_comb begin
        rf_le = 1'b0;
        rf_rw = '0;
        rf_pw = '0;
        if (rst_n) begin
            if (a_act) begin
                rf_le = 1'b1;
                rf_rw = wb_rw;
                rf_pw = wb_pw;
            end else if (lu_valid) begin
                rf_le = (lu_rw != REG_AW'(REG_ZERO));
                rf_rw = lu_rw;
                rf_pw = lu_pw;
            end
        end
    end

    // Starvation tracking: once source B has been refused for STARVE_LIMIT
    // cycles in WAIT, freeze the pipeline until B gets its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            force_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lu_valid && !lu_ready) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (lu_ready) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(STARVE_LIMIT)) begin
                        state   <= ST_FORCE;
                        force_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_FORCE: begin
                    if (lu_ready) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                        force_q  <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wait_cnt <= '0;
                    force_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_stall = force_q;

    rf_scoreboard #(
        .REG_AW      (REG_AW),
        .MAX_PENDING (MAX_PENDING),
        .CNT_W       (CNT_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_long    (iss_long),
        .iss_rs      (iss_rs),
        .iss_rt      (iss_rt),
        .iss_rd      (iss_rd),
        .force_stall (force_q),
        .clr_en      (lu_ready),
        .clr_rw      (lu_rw),
        .iss_stall   (iss_stall),
        .busy        (sb_busy),
        .pending_cnt (pending_cnt)
    );

    a_lu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (lu_valid && !lu_ready) |=> lu_valid);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - self-checking bench for rf_write_scheduler
module tb_rf_write_scheduler;

    localparam int STARVE_LIMIT = 4;
    localparam int MAX_PENDING  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_le = 1'b0;
    logic [4:0]  wb_rw = '0;
    logic [31:0] wb_pw = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_rw = '0;
    logic [31:0] lu_pw = '0;
    logic        lu_ready;
    logic        iss_valid = 1'b0;
    logic        iss_long = 1'b0;
    logic [4:0]  iss_rs = '0;
    logic [4:0]  iss_rt = '0;
    logic [4:0]  iss_rd = '0;
    logic        iss_stall;
    logic        pipe_stall;
    logic        rf_le;
    logic [4:0]  rf_rw;
    logic [31:0] rf_pw;
    logic [31:0] sb_busy;
    logic [2:0]  pending_cnt;

    int n_vec = 0;
    int n_err = 0;

    rf_write_scheduler #(
        .DATA_W       (32),
        .REG_AW       (5),
        .MAX_PENDING  (MAX_PENDING),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_le       (wb_le),
        .wb_rw       (wb_rw),
        .wb_pw       (wb_pw),
        .lu_valid    (lu_valid),
        .lu_rw       (lu_rw),
        .lu_pw       (lu_pw),
        .lu_ready    (lu_ready),
        .iss_valid   (iss_valid),
        .iss_long    (iss_long),
        .iss_rs      (iss_rs),
        .iss_rt      (iss_rt),
        .iss_rd      (iss_rd),
        .iss_stall   (iss_stall),
        .pipe_stall  (pipe_stall),
        .rf_le       (rf_le),
        .rf_rw       (rf_rw),
        .rf_pw       (rf_pw),
        .sb_busy     (sb_busy),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: set of busy registers, list of outstanding long ops,
    // and the length of source B's current run of refused cycles.
    logic [31:0] m_busy = '0;
    int          m_pending = 0;
    int          m_denied = 0;
    int          m_q[$];
    bit          m_last_grant = 1'b0;

    function automatic bit m_force();
        return m_denied > STARVE_LIMIT;
    endfunction

    function automatic bit m_a_act();
        return wb_le && (wb_rw != 5'd0);
    endfunction

    function automatic bit exp_iss_stall();
        if (!rst_n || !iss_valid) return 1'b0;
        return m_busy[iss_rs] || m_busy[iss_rt] || m_busy[iss_rd]
            || (iss_long && m_pending == MAX_PENDING) || m_force();
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit grant;
        bit fire;
        int idx;
        if (!rst_n) begin
            m_busy = '0;
            m_pending = 0;
            m_denied = 0;
            m_q.delete();
            m_last_grant = 1'b0;
        end else begin
            grant = lu_valid && !m_a_act();
            fire  = iss_valid && !exp_iss_stall();
            if (fire && iss_long) begin
                m_pending++;
                m_q.push_back(int'(iss_rd));
                if (iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
            end
            if (grant) begin
                m_pending--;
                if (lu_rw != 5'd0) m_busy[lu_rw] = 1'b0;
                idx = -1;
                for (int i = 0; i < m_q.size(); i++) begin
                    if (idx < 0 && m_q[i] == int'(lu_rw)) idx = i;
                end
                if (idx >= 0) m_q.delete(idx);
            end
            if (grant || !lu_valid) m_denied = 0;
            else m_denied++;
            m_last_grant = grant;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic        e_le;
        logic [4:0]  e_rw;
        logic [31:0] e_pw;
        e_le = 1'b0;
        e_rw = '0;
        e_pw = '0;
        if (rst_n) begin
            if (m_a_act()) begin
                e_le = 1'b1;
                e_rw = wb_rw;
                e_pw = wb_pw;
            end else if (lu_valid) begin
                e_le = (lu_rw != 5'd0);
                e_rw = lu_rw;
                e_pw = lu_pw;
            end
        end
        chk("rf_le", 32'(rf_le), 32'(e_le));
        chk("rf_rw", 32'(rf_rw), 32'(e_rw));
        chk("rf_pw", rf_pw, e_pw);
        chk("lu_ready", 32'(lu_ready), 32'(rst_n && lu_valid && !m_a_act()));
        chk("iss_stall", 32'(iss_stall), 32'(exp_iss_stall()));
        chk("pipe_stall", 32'(pipe_stall), 32'(rst_n && m_force()));
        chk("sb_busy", sb_busy, m_busy);
        chk("pending_cnt", 32'(pending_cnt), 32'(m_pending));
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_le = 1'b0; wb_rw = '0; wb_pw = '0;
        lu_valid = 1'b0; lu_rw = '0; lu_pw = '0;
        iss_valid = 1'b0; iss_long = 1'b0; iss_rs = '0; iss_rt = '0; iss_rd = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_issue(input bit lng, input int rs, input int rt, input int rd);
        iss_valid = 1'b1;
        iss_long  = lng;
        iss_rs    = 5'(rs);
        iss_rt    = 5'(rt);
        iss_rd    = 5'(rd);
    endtask

    task automatic gen_random(input int dens);
        if (!(lu_valid && !m_last_grant)) begin
            lu_valid = 1'b0;
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                lu_valid = 1'b1;
                lu_rw    = 5'(m_q[0]);
                lu_pw    = $urandom();
            end
        end
        if (m_force()) wb_le = 1'b0;
        else wb_le = ($urandom_range(0, 99) < dens);
        wb_rw     = 5'($urandom_range(0, 31));
        wb_pw     = $urandom();
        iss_valid = ($urandom_range(0, 9) < 7);
        iss_long  = ($urandom_range(0, 9) < 4);
        iss_rs    = 5'($urandom_range(0, 12));
        iss_rt    = 5'($urandom_range(0, 12));
        iss_rd    = 5'($urandom_range(0, 12));
    endtask

    initial begin
        idle_inputs();
        do_reset();

        // reset state
        settle();
        chk("rst_busy", sb_busy, 32'h0);
        chk("rst_pending", 32'(pending_cnt), 32'd0);
        chk("rst_rf_le", 32'(rf_le), 32'd0);
        chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        advance();

        // source A alone, then A to r0
        wb_le = 1'b1; wb_rw = 5'd5; wb_pw = 32'hDEAD;
        settle();
        chk("a_only_le", 32'(rf_le), 32'd1);
        chk("a_only_rw", 32'(rf_rw), 32'd5);
        chk("a_only_pw", rf_pw, 32'hDEAD);
        chk("a_only_ready", 32'(lu_ready), 32'd0);
        advance();
        wb_rw = 5'd0;
        settle();
        chk("a_r0_le", 32'(rf_le), 32'd0);
        advance();
        idle_inputs();

        // collision: A wins, B goes next cycle
        set_issue(1'b1, 0, 0, 7);
        settle();
        chk("coll_issue", 32'(iss_stall), 32'd0);
        advance();
        idle_inputs();
        wb_le = 1'b1; wb_rw = 5'd3; wb_pw = 32'h55;
        lu_valid = 1'b1; lu_rw = 5'd7; lu_pw = 32'h11;
        settle();
        chk("coll_a_rw", 32'(rf_rw), 32'd3);
        chk("coll_a_pw", rf_pw, 32'h55);
        chk("coll_ready0", 32'(lu_ready), 32'd0);
        advance();
        wb_le = 1'b0;
        settle();
        chk("coll_ready1", 32'(lu_ready), 32'd1);
        chk("coll_b_rw", 32'(rf_rw), 32'd7);
        chk("coll_b_pw", rf_pw, 32'h11);
        advance();
        lu_valid = 1'b0;
        settle();
        chk("coll_pipe", 32'(pipe_stall), 32'd0);
        chk("coll_pending", 32'(pending_cnt), 32'd0);
        advance();

        // starvation: refused 5 edges in a row -> force
        do_reset();
        set_issue(1'b1, 0, 0, 6);
        settle();
        advance();
        idle_inputs();
        wb_le = 1'b1; wb_rw = 5'd3; wb_pw = 32'h33;
        lu_valid = 1'b1; lu_rw = 5'd6; lu_pw = 32'h66;
        set_issue(1'b0, 1, 2, 3);
        for (int k = 1; k <= 6; k++) begin
            settle();
            chk("starve_pipe", 32'(pipe_stall), 32'(k == 6));
            chk("starve_iss", 32'(iss_stall), 32'(k == 6));
            advance();
        end
        wb_le = 1'b0;
        settle();
        chk("starve_grant", 32'(lu_ready), 32'd1);
        chk("starve_hold", 32'(pipe_stall), 32'd1);
        advance();
        lu_valid = 1'b0;
        settle();
        chk("starve_release", 32'(pipe_stall), 32'd0);
        advance();

        // RAW hazard on a long-op destination
        do_reset();
        set_issue(1'b1, 1, 2, 9);
        settle();
        advance();
        set_issue(1'b0, 9, 0, 10);
        settle();
        chk("raw_busy9", sb_busy, 32'h200);
        chk("raw_stall", 32'(iss_stall), 32'd1);
        advance();
        lu_valid = 1'b1; lu_rw = 5'd9; lu_pw = 32'h99;
        settle();
        chk("raw_clear_cycle", 32'(iss_stall), 32'd1);
        advance();
        lu_valid = 1'b0;
        settle();
        chk("raw_released", 32'(iss_stall), 32'd0);
        advance();

        // pending limit
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            set_issue(1'b1, 0, 0, r);
            settle();
            advance();
        end
        set_issue(1'b1, 0, 0, 5);
        settle();
        chk("full_pending", 32'(pending_cnt), 32'd4);
        chk("full_busy", sb_busy, 32'h1E);
        chk("full_long_stall", 32'(iss_stall), 32'd1);
        advance();
        set_issue(1'b0, 10, 0, 11);
        settle();
        chk("full_short_go", 32'(iss_stall), 32'd0);
        advance();

        // async reset mid-WAIT, then an r0 completion from B
        do_reset();
        set_issue(1'b1, 0, 0, 4);
        settle();
        advance();
        set_issue(1'b1, 0, 0, 9);
        settle();
        advance();
        idle_inputs();
        wb_le = 1'b1; wb_rw = 5'd3;
        lu_valid = 1'b1; lu_rw = 5'd4;
        set_issue(1'b0, 4, 0, 12);
        settle();
        chk("arst_pre_busy", sb_busy, 32'h210);
        advance();
        settle();
        advance();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", sb_busy, 32'h0);
        chk("arst_pending", 32'(pending_cnt), 32'd0);
        chk("arst_rf_le", 32'(rf_le), 32'd0);
        chk("arst_ready", 32'(lu_ready), 32'd0);
        chk("arst_iss", 32'(iss_stall), 32'd0);
        chk("arst_pipe", 32'(pipe_stall), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_issue(1'b1, 0, 0, 0);
        settle();
        advance();
        idle_inputs();
        lu_valid = 1'b1; lu_rw = 5'd0; lu_pw = 32'h77;
        settle();
        chk("r0_pending1", 32'(pending_cnt), 32'd1);
        chk("r0_rf_le", 32'(rf_le), 32'd0);
        chk("r0_ready", 32'(lu_ready), 32'd1);
        advance();
        lu_valid = 1'b0;
        settle();
        chk("r0_pending0", 32'(pending_cnt), 32'd0);
        advance();

        // randomized traffic at several writeback densities
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            int dens;
            dens = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 40 : 10);
            for (int c = 0; c < 400; c++) begin
                gen_random(dens);
                settle();
                advance();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
